// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART loopback types and constants
package uart_pkg;

  localparam int UART_DW  = 8;
  localparam int CLK_FREQ = 50000000;
  localparam int UART_BPS = 115200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buf_if.sv
// rtl/uart_tx_buf_if.sv - receiver-to-buffer-to-transmitter handshake bundle
interface uart_tx_buf_if;
  import uart_pkg::*;

  logic               wr_en;
  logic [UART_DW-1:0] wr_data;
  logic               tx_busy;
  logic               uart_en;
  logic [UART_DW-1:0] uart_din;

  // master: receiver + transmitter side; slave: the buffer itself
  modport master (
    output wr_en, wr_data, tx_busy,
    input  uart_en, uart_din
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output uart_en, uart_din
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x byte register array, sync write, comb read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [UART_DW-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [UART_DW-1:0] o_rd_data
);

  logic [UART_DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - byte FIFO and start-pulse sequencer feeding the UART transmitter
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BUSY_TMO = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  uart_tx_buf_if.slave      u_if,
  output logic [ADDR_W:0]   o_fifo_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_tmo_err
);

  localparam int              TMO_W    = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  tx_state_e          r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_uart_en;
  logic [UART_DW-1:0] r_uart_din;
  logic               r_overflow;
  logic               r_tmo_err;
  logic [TMO_W-1:0]   r_tmo_cnt;

  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ADDR_W:0]    w_count_nxt;
  logic [UART_DW-1:0] w_rd_data;

  // A full FIFO still accepts a write when the same edge frees the head slot
  assign w_pop  = (r_state == IDLE) && !r_empty && !u_if.tx_busy;
  assign w_push = u_if.wr_en && (!r_full || w_pop);
  assign w_drop = u_if.wr_en && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk     (i_sys_clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (u_if.wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_uart_en  <= 1'b0;
      r_uart_din <= '0;
      r_overflow <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_uart_en <= 1'b0;
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == DEPTH_C);
      r_empty   <= (w_count_nxt == '0);
      if (w_push) r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_uart_din <= w_rd_data;
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_uart_en <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (u_if.tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!u_if.tx_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign u_if.uart_en  = r_uart_en;
  assign u_if.uart_din = r_uart_din;
  assign o_fifo_count  = r_count;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_overflow    = r_overflow;
  assign o_tmo_err     = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf with a queue-based transmitter model
module tb_uart_tx_buf;

  localparam int DEPTH    = 16;
  localparam int BUSY_TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] o_fifo_count;
  logic       o_full, o_empty, o_overflow, o_tmo_err;

  uart_tx_buf_if bus ();

  uart_tx_buf dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .u_if         (bus),
    .o_fifo_count (o_fifo_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_overflow   (o_overflow),
    .o_tmo_err    (o_tmo_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  logic force_busy = 1'b0;
  logic no_busy    = 1'b0;
  logic rand_busy  = 1'b0;
  logic model_busy = 1'b0;
  logic en_prev    = 1'b0;
  int   busy_len   = 5;
  int   busy_left  = 0;

  assign bus.tx_busy = force_busy | model_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: captures each start pulse and holds busy for a frame time
  always @(negedge clk) begin
    if (bus.uart_en) begin
      chk("pulse_while_busy", 32'(bus.tx_busy), 32'd0);
      chk("pulse_width", 32'(en_prev), 32'd0);
      sent_q.push_back(bus.uart_din);
      if (!no_busy) begin
        busy_left  = rand_busy ? int'($urandom_range(1, 20)) : busy_len;
        model_busy = 1'b1;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      model_busy = (busy_left > 0);
    end
    en_prev = bus.uart_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_drain(int n, int budget, string tag);
    int k = 0;
    while (!(sent_q.size() >= n && !bus.tx_busy && o_empty) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drain_in_time"}, 32'(k < budget), 32'd1);
    repeat (3) tick();
  endtask

  task automatic cmp_sent(string tag);
    chk({tag, "_n_sent"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_empty"}, 32'(o_empty), 32'd1);
    chk({tag, "_full"}, 32'(o_full), 32'd0);
    chk({tag, "_count"}, 32'(o_fifo_count), 32'd0);
    chk({tag, "_uart_en"}, 32'(bus.uart_en), 32'd0);
    chk({tag, "_uart_din"}, 32'(bus.uart_din), 32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
    chk({tag, "_tmo_err"}, 32'(o_tmo_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         found;
    int         gap;
    logic [7:0] b;

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // power-on reset
    tick();
    tick();
    rst = 1'b0;
    chk_reset("por");

    // single byte: pulse two edges after the write edge
    busy_len = 5;
    write_byte(8'hA5);
    exp_q.push_back(8'hA5);
    chk("single_empty_after_wr", 32'(o_empty), 32'd0);
    chk("single_count_after_wr", 32'(o_fifo_count), 32'd1);
    tick();
    chk("single_din_after_pop", 32'(bus.uart_din), 32'hA5);
    chk("single_en_before_pulse", 32'(bus.uart_en), 32'd0);
    chk("single_count_after_pop", 32'(o_fifo_count), 32'd0);
    tick();
    chk("single_en_pulse", 32'(bus.uart_en), 32'd1);
    chk("single_din_at_pulse", 32'(bus.uart_din), 32'hA5);
    tick();
    chk("single_en_drop", 32'(bus.uart_en), 32'd0);
    wait_drain(1, 50, "single");
    cmp_sent("single");

    // burst under long frames
    busy_len = 100;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    wait_drain(5, 700, "burst");
    cmp_sent("burst");

    // full FIFO with a pop on the same edge as a write
    busy_len   = 3;
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    chk("fp_full", 32'(o_full), 32'd1);
    chk("fp_count_full", 32'(o_fifo_count), 32'(DEPTH));
    force_busy = 1'b0;
    write_byte(8'h77);
    exp_q.push_back(8'h77);
    chk("fp_count_stays", 32'(o_fifo_count), 32'(DEPTH));
    chk("fp_full_stays", 32'(o_full), 32'd1);
    chk("fp_no_overflow", 32'(o_overflow), 32'd0);
    wait_drain(DEPTH + 1, 400, "fp");
    cmp_sent("fp");

    // overflow: 17th write dropped
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_byte(8'h40 + 8'(i));
      if (i < DEPTH) exp_q.push_back(8'h40 + 8'(i));
      if (i == DEPTH - 1) begin
        chk("ovf_full_at_16", 32'(o_full), 32'd1);
        chk("ovf_none_at_16", 32'(o_overflow), 32'd0);
      end
    end
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_count", 32'(o_fifo_count), 32'(DEPTH));
    force_busy = 1'b0;
    wait_drain(DEPTH, 400, "ovf");
    cmp_sent("ovf");
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // timeout: transmitter never reports busy
    no_busy = 1'b1;
    write_byte(8'hB1);
    write_byte(8'hB2);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.uart_en) found = 1'b1;
      else tick();
    end
    chk("tmo_pulse_seen", 32'(found), 32'd1);
    for (int k = 1; k <= BUSY_TMO; k++) begin
      tick();
      if (k == BUSY_TMO - 1) chk("tmo_not_yet", 32'(o_tmo_err), 32'd0);
      if (k == BUSY_TMO)     chk("tmo_set", 32'(o_tmo_err), 32'd1);
    end
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (sent_q.size() >= 2) found = 1'b1;
      else tick();
    end
    chk("tmo_next_sent", 32'(found), 32'd1);
    repeat (BUSY_TMO + 6) tick();
    cmp_sent("tmo");
    no_busy = 1'b0;

    // reset in the middle of a burst clears sticky flags and pending bytes
    busy_len = 100;
    for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
    exp_q.push_back(8'hC0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    tick();
    chk("midrst_en_after", 32'(bus.uart_en), 32'd0);
    repeat (150) tick();
    cmp_sent("midrst");

    // random bytes, gaps and frame lengths
    rand_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      write_byte(b);
      exp_q.push_back(b);
      gap = int'($urandom_range(0, 5));
      repeat (gap) tick();
    end
    wait_drain(12, 500, "rand");
    cmp_sent("rand");
    chk("rand_no_overflow", 32'(o_overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Byte buffer and transmit sequencer between the UART receiver and the UART transmitter in the loopback path. It captures each received byte on the receiver's done pulse into a circular FIFO. When the transmitter is idle, it pops the head byte and issues a single-cycle start pulse, so bursts of received bytes are never lost while a send is still in progress.

Parameters:
DEPTH, 16, FIFO depth in bytes; must be a power of two, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.
BUSY_TMO, 8, cycles to wait for tx_busy to rise after uart_en before abandoning the handshake.

Ports:
sys_clk  in  1  system clock, 50 MHz; all logic on the rising edge.
sys_rst  in  1  synchronous reset, active-high.
wr_en  in  1  one-cycle write strobe; connects to the receiver done pulse.
wr_data  in  8  byte to enqueue; sampled when wr_en=1.
tx_busy  in  1  transmitter busy flag; high while a frame is being shifted out.
uart_en  out  1  one-cycle start pulse to the transmitter.
uart_din  out  8  byte to transmit; held stable from the pulse until the next pop.
fifo_count  out  ADDR_W+1  number of bytes currently stored, 0..DEPTH.
full  out  1  fifo_count==DEPTH.
empty  out  1  fifo_count==0.
overflow  out  1  sticky; set when a write is dropped.
tmo_err  out  1  sticky; set when the busy handshake times out.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values:
  - Pointers and count are 0, so empty=1 and full=0.
  - uart_en=0, uart_din=8'h00, overflow=0, tmo_err=0.
  - FSM returns to IDLE.
  - FIFO memory contents are don't-care.
- Reset mid-operation: takes effect at the next edge. Any pending pulse is cancelled and the state returns to IDLE. A frame already in flight inside the transmitter is not aborted.
- Write rules:
  - When wr_en=1 and the FIFO is not full: store wr_data at wr_ptr, then increment wr_ptr (wraps modulo DEPTH).
  - When wr_en=1, full=1 and no pop occurs in the same cycle: drop the byte and set overflow; pointers are unchanged.
  - When the FIFO is full but a pop occurs in the same cycle: the write is accepted and count stays at DEPTH.
- Count arithmetic: push only gives +1, pop only gives -1, push and pop together give no change. The count never wraps below 0 or above DEPTH.
- FSM states:
  - IDLE: if empty=0 and tx_busy=0, pop. uart_din<=mem[rd_ptr], rd_ptr increments (wraps), go to START. Otherwise stay.
  - START: uart_en=1 for exactly this one cycle. Clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Else increment the counter; when it reaches BUSY_TMO, set tmo_err and go to IDLE.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with the transmitter idle appears as follows.
  - empty=0 after edge N.
  - Popped at edge N+1, so uart_din is valid after edge N+1.
  - uart_en is high during the cycle after edge N+2.
- Ordering: output order is strictly FIFO. uart_en is never asserted twice without tx_busy having risen and fallen in between, except after a timeout.
- Bypass: there is no bypass path. A write and a pop in the same cycle on an empty FIFO cannot occur, because a pop requires empty=0 before the edge.
- Flag registration: full, empty and fifo_count are registered. They reflect the state after the most recent edge.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - Byte width constant UART_DW=8.
  - Defaults CLK_FREQ=50000000 and UART_BPS=115200 for neighbouring blocks.
- Sub-module uart_fifo_mem: dual-port register array, DEPTH x 8, with a synchronous write port and a combinational read by address.
- The pointers, count and FSM stay in uart_tx_buf.

Test Plan:
- Reset: assert sys_rst for 2 cycles mid-burst -> next cycle empty=1, fifo_count=0, uart_en=0, uart_din=8'h00, overflow=0, tmo_err=0.
- Single byte: write 8'hA5 with the transmitter model idle -> uart_en is a 1-cycle pulse 2 cycles after the write edge. uart_din=8'hA5, and fifo_count returns to 0.
- Burst: write 8'h01..8'h05 on consecutive cycles while the model holds tx_busy high for 100 cycles per byte -> 5 pulses in order 01..05, each only after tx_busy falls.
- Overflow: with tx_busy stuck high, write 17 bytes -> full=1 after the 16th write, the 17th byte is dropped and overflow=1. The drained order is bytes 1..16.
- Full plus pop: FIFO full, pop in IDLE coincides with wr_en for 8'h77 -> fifo_count stays 16, no overflow, and 8'h77 is the last byte drained.
- Timeout: the transmitter model never raises tx_busy -> tmo_err=1 exactly BUSY_TMO=8 cycles after the pulse. The FSM returns to IDLE and sends the next byte.
